circuit1_seq_ctrl: RTL and testbench



---
 rtl/circuit1_seq_ctrl_if.sv | 13 +
 rtl/circuit1_seq_ctrl.sv | 82 ++++++++
 tb/tb_circuit1_seq_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/circuit1_seq_ctrl_if.sv
// circuit1_seq_ctrl_if: start handshake, operand and result bundle for circuit1_seq_ctrl
interface circuit1_seq_ctrl_if #(parameter int DATAW = 8);
  logic             start_i;
  logic [DATAW-1:0] a_i;
  logic [DATAW-1:0] b_i;
  logic [DATAW-1:0] c_i;
  logic [DATAW-1:0] z_o;
  logic [2*DATAW-1:0] x_o;
  logic             busy_o;
  logic             done_o;
  modport master (output start_i, a_i, b_i, c_i, input z_o, x_o, busy_o, done_o);
  modport slave  (input start_i, a_i, b_i, c_i, output z_o, x_o, busy_o, done_o);
endinterface

// File: rtl/circuit1_seq_ctrl.sv
// circuit1_seq_ctrl: multi-cycle Circuit1 sharing one add/sub unit, one comparator and one multiplier
module circuit1_seq_ctrl #(
  parameter int DATAW   = 8,
  parameter int MUL_LAT = 2
) (
  input logic Clk,
  input logic Rst,
  circuit1_seq_ctrl_if.slave io
);
  localparam int W2 = 2 * DATAW;
  typedef enum logic [2:0] {IDLE, ADD_D, ADD_E, CMP, MUL, SUB, DONE} state_t;
  state_t state_q, state_d;
  logic signed [DATAW-1:0] a_q, b_q, c_q, d_q, e_q, z_q;
  logic g_q;
  logic [3:0] cnt_q;
  logic signed [W2-1:0] f_q, x_q, a_x, b_x, c_x, d_x, op1, op2, alu, prod;
  assign a_x = {{DATAW{a_q[DATAW-1]}}, a_q};
  assign b_x = {{DATAW{b_q[DATAW-1]}}, b_q};
  assign c_x = {{DATAW{c_q[DATAW-1]}}, c_q};
  assign d_x = {{DATAW{d_q[DATAW-1]}}, d_q};
  // operand muxes idle at zero outside the three states that own the shared unit
  always_comb begin
    op1 = state_q == SUB ? f_q : (state_q == ADD_D || state_q == ADD_E) ? a_x : '0;
    op2 = state_q == ADD_D ? b_x : state_q == ADD_E ? c_x : state_q == SUB ? d_x : '0;
    alu = state_q == SUB ? op1 - op2 : op1 + op2;
    prod = a_q * c_q;
  end
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = io.start_i ? ADD_D : IDLE;
      ADD_D:   state_d = ADD_E;
      ADD_E:   state_d = CMP;
      CMP:     state_d = MUL;
      MUL:     state_d = cnt_q == '0 ? SUB : MUL;
      SUB:     state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    io.busy_o = state_q != IDLE;
    io.done_o = state_q == DONE;
    io.z_o = z_q;
    io.x_o = x_q;
  end
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      d_q <= '0;
      e_q <= '0;
      g_q <= 1'b0;
      f_q <= '0;
      cnt_q <= '0;
      z_q <= '0;
      x_q <= '0;
    end else begin
      if (state_q == IDLE && io.start_i) begin
        a_q <= io.a_i;
        b_q <= io.b_i;
        c_q <= io.c_i;
      end
      if (state_q == ADD_D) d_q <= alu[DATAW-1:0];
      if (state_q == ADD_E) e_q <= alu[DATAW-1:0];
      if (state_q == CMP) begin
        g_q <= d_q > e_q;
        cnt_q <= 4'(MUL_LAT - 1);
      end
      if (state_q == MUL) begin
        if (cnt_q == '0) f_q <= prod;
        else cnt_q <= cnt_q - 4'd1;
      end
      if (state_q == SUB) begin
        x_q <= alu;
        z_q <= g_q ? e_q : d_q;
      end
    end
endmodule

// File: tb/tb_circuit1_seq_ctrl.sv
// tb_circuit1_seq_ctrl: directed and random runs of circuit1_seq_ctrl against an arithmetic reference model
module tb_circuit1_seq_ctrl;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] mz;
  logic [15:0] mx;
  logic [23:0] ent;
  logic [23:0] q1[$];
  logic [23:0] q2[$];
  int nd;
  always #5 Clk = ~Clk;
  circuit1_seq_ctrl_if #(.DATAW(8)) i0 ();
  circuit1_seq_ctrl_if #(.DATAW(8)) i1 ();
  circuit1_seq_ctrl_if #(.DATAW(8)) i2 ();
  circuit1_seq_ctrl #(.DATAW(8), .MUL_LAT(2)) dut0 (.Clk(Clk), .Rst(Rst), .io(i0));
  circuit1_seq_ctrl #(.DATAW(8), .MUL_LAT(1)) dut1 (.Clk(Clk), .Rst(Rst), .io(i1));
  circuit1_seq_ctrl #(.DATAW(8), .MUL_LAT(5)) dut2 (.Clk(Clk), .Rst(Rst), .io(i2));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic void model(input logic [7:0] a, b, c, output logic [7:0] z, output logic [15:0] x);
    int sa, sb, sc;
    byte d, e;
    sa = int'($signed(a));
    sb = int'($signed(b));
    sc = int'($signed(c));
    d = byte'(sa + sb);
    e = byte'(sa + sc);
    z = d > e ? e : d;
    x = 16'(sa * sc - int'(d));
  endfunction
  task automatic run(input logic [7:0] a, b, c, input bit poke);
    logic [7:0] ez;
    logic [15:0] ex;
    int lat, nb;
    model(a, b, c, ez, ex);
    i0.start_i = 1'b1;
    i0.a_i = a;
    i0.b_i = b;
    i0.c_i = c;
    @(negedge Clk);
    i0.start_i = 1'b0;
    lat = 0;
    nb = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      i0.a_i = 8'($urandom);
      i0.b_i = 8'($urandom);
      i0.c_i = 8'($urandom);
      i0.start_i = poke && (k == 2 || k == 7);
      if (i0.busy_o) nb++;
      if (i0.done_o) begin
        lat = k;
        chk("run z", 32'(i0.z_o), 32'(ez));
        chk("run x", 32'(i0.x_o), 32'(ex));
      end
      @(negedge Clk);
    end
    i0.start_i = 1'b0;
    chk("run latency", lat, 7);
    chk("run busy cycles", nb, 7);
    chk("run done pulse width", 32'(i0.done_o), 0);
    chk("run back to idle", 32'(i0.busy_o), 0);
  endtask
  initial begin
    {i0.start_i, i0.a_i, i0.b_i, i0.c_i} = '0;
    {i1.start_i, i1.a_i, i1.b_i, i1.c_i} = '0;
    {i2.start_i, i2.a_i, i2.b_i, i2.c_i} = '0;
    #1 Rst = 1'b0;
    #1;
    chk("reset z", 32'(i0.z_o), 0);
    chk("reset x", 32'(i0.x_o), 0);
    chk("reset busy", 32'(i0.busy_o), 0);
    chk("reset done", 32'(i0.done_o), 0);
    @(negedge Clk) Rst = 1'b1;
    @(negedge Clk);
    run(8'd3, 8'd4, 8'd5, 1'b0);
    chk("t1 z", 32'(i0.z_o), 32'h07);
    chk("t1 x", 32'(i0.x_o), 32'h0008);
    run(8'hFE, 8'd10, 8'hFD, 1'b0);
    chk("t2 z", 32'(i0.z_o), 32'hFB);
    chk("t2 x", 32'(i0.x_o), 32'hFFFE);
    run(8'd100, 8'd100, 8'h80, 1'b0);
    chk("t3 z", 32'(i0.z_o), 32'hC8);
    chk("t3 x", 32'(i0.x_o), 32'hCE38);
    repeat (6) run(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    run(8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
    nd = 0;
    repeat (10) begin
      if (i0.done_o) nd++;
      @(negedge Clk);
    end
    chk("ignored start no extra done", nd, 0);
    run(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    run(8'd3, 8'd4, 8'd5, 1'b0);
    i0.start_i = 1'b1;
    i0.a_i = 8'd9;
    i0.b_i = 8'd9;
    i0.c_i = 8'd9;
    @(negedge Clk);
    i0.start_i = 1'b0;
    repeat (3) @(negedge Clk);
    #1 Rst = 1'b0;
    #1;
    chk("abort z", 32'(i0.z_o), 0);
    chk("abort x", 32'(i0.x_o), 0);
    chk("abort busy", 32'(i0.busy_o), 0);
    chk("abort done", 32'(i0.done_o), 0);
    @(negedge Clk);
    Rst = 1'b1;
    nd = 0;
    repeat (12) begin
      @(negedge Clk);
      if (i0.done_o) nd++;
    end
    chk("abort no done", nd, 0);
    run(8'd3, 8'd4, 8'd5, 1'b0);
    chk("t5 z", 32'(i0.z_o), 32'h07);
    chk("t5 x", 32'(i0.x_o), 32'h0008);
    // start held high: a run is latched every 6+MUL_LAT cycles, done lands 5+MUL_LAT after each latch
    for (int j = 0; j < 45; j++) begin
      chk("cont L1 done", 32'(i1.done_o), 32'(j % 7 == 6));
      chk("cont L5 done", 32'(i2.done_o), 32'(j % 11 == 10));
      if (j % 7 == 6 && q1.size() > 0) begin
        ent = q1.pop_front();
        chk("cont L1 z", 32'(i1.z_o), 32'(ent[23:16]));
        chk("cont L1 x", 32'(i1.x_o), 32'(ent[15:0]));
      end
      if (j % 11 == 10 && q2.size() > 0) begin
        ent = q2.pop_front();
        chk("cont L5 z", 32'(i2.z_o), 32'(ent[23:16]));
        chk("cont L5 x", 32'(i2.x_o), 32'(ent[15:0]));
      end
      i1.start_i = 1'b1;
      i1.a_i = 8'($urandom);
      i1.b_i = 8'($urandom);
      i1.c_i = 8'($urandom);
      i2.start_i = 1'b1;
      i2.a_i = 8'($urandom);
      i2.b_i = 8'($urandom);
      i2.c_i = 8'($urandom);
      if (j % 7 == 0) begin
        model(i1.a_i, i1.b_i, i1.c_i, mz, mx);
        q1.push_back({mz, mx});
      end
      if (j % 11 == 0) begin
        model(i2.a_i, i2.b_i, i2.c_i, mz, mx);
        q2.push_back({mz, mx});
      end
      @(negedge Clk);
    end
    i1.start_i = 1'b0;
    i2.start_i = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
